// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: access encodings,
// FSM states and the access-size helpers.
package dmem_pkg;

  localparam logic [3:0] SLT_LB  = 4'b0000;
  localparam logic [3:0] SLT_LH  = 4'b0001;
  localparam logic [3:0] SLT_LW  = 4'b0010;
  localparam logic [3:0] SLT_LBU = 4'b0100;
  localparam logic [3:0] SLT_LHU = 4'b0101;
  localparam logic [3:0] SLT_SB  = 4'b1000;
  localparam logic [3:0] SLT_SH  = 4'b1001;
  localparam logic [3:0] SLT_SW  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT2 = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Access size in bytes; 0 marks an unlisted encoding.
  function automatic logic [2:0] size_bytes(input logic [3:0] sltype);
    case (sltype)
      SLT_LB, SLT_LBU, SLT_SB: size_bytes = 3'd1;
      SLT_LH, SLT_LHU, SLT_SH: size_bytes = 3'd2;
      SLT_LW, SLT_SW:          size_bytes = 3'd4;
      default:                 size_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] size);
    case (size)
      3'd1:    lane_mask = 4'b0001;
      3'd2:    lane_mask = 4'b0011;
      3'd4:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bundle of the load/store unit.
// A request transfers on a rising edge where req_valid and req_ready are both 1;
// the response is a single-cycle rsp_valid strobe with rsp_rdata/rsp_err.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sltype;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_sltype,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_sltype,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ext.sv
// Load data extension: sign/zero extends the right-aligned raw load value.
module dmem_ext (
  input  logic [2:0]  sel,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (sel)
      3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
      3'b100:  ext = {24'd0, raw[7:0]};
      3'b101:  ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressed data memory with load/store unit; word-crossing accesses
// take a second beat on word W+1. req_valid/req_ready: transfer when both are 1.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS      = 256,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_sltype,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output state_t      dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t state, state_nx;
  logic started;

  logic [AW-1:0] req_idx;
  logic [1:0]    req_off;
  logic [2:0]    req_size;
  logic          req_split, req_err, accept;
  logic [7:0]    be8;
  logic [63:0]   data64;

  assign req_idx   = req_addr[AW+1:2];
  assign req_off   = req_addr[1:0];
  assign req_size  = size_bytes(req_sltype);
  assign req_split = (({1'b0, req_off} + req_size) > 3'd4);
  // Out of range: any upper address bit, or a split whose second word wraps.
  assign req_err   = (req_size == 3'd0) || (|req_addr[31:AW+2]) ||
                     (req_split && (req_idx == '1)) ||
                     (req_split && !ALLOW_MISALIGNED);
  assign accept    = req_valid && req_ready;
  assign be8       = {4'b0000, lane_mask(req_size)} << req_off;
  assign data64    = {32'd0, req_wdata} << {req_off, 3'b000};

  logic          st_q, err_q;
  logic [2:0]    type_q;
  logic [1:0]    off_q;
  logic [AW-1:0] hi_idx_q;
  logic [31:0]   hi_data_q;
  logic [3:0]    hi_be_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      started   <= 1'b0;
      st_q      <= 1'b0;
      err_q     <= 1'b0;
      type_q    <= 3'd0;
      off_q     <= 2'd0;
      hi_idx_q  <= '0;
      hi_data_q <= 32'd0;
      hi_be_q   <= 4'd0;
    end else begin
      state   <= state_nx;
      started <= 1'b1;
      if (accept) begin
        st_q      <= req_sltype[3];
        err_q     <= req_err;
        type_q    <= req_sltype[2:0];
        off_q     <= req_off;
        hi_idx_q  <= req_idx + 1'b1;
        hi_data_q <= data64[63:32];
        hi_be_q   <= be8[7:4];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (req_err || !req_split) ? RESP : BEAT2;
      BEAT2:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  logic        in_beat2, wr_lo, wr_hi;
  logic [31:0] rd_lo;
  logic [23:0] rd_hi;

  assign in_beat2 = (state == BEAT2);
  assign wr_lo    = accept && req_sltype[3] && !req_err;
  // Gating with rst_n keeps an abandoned split from writing its second word.
  assign wr_hi    = in_beat2 && st_q && rst_n;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0]    mem [DEPTH_WORDS];
    logic [AW-1:0] addr_l;
    logic          we_l;
    logic [7:0]    wd_l;
    logic [7:0]    rd_lo_b;

    assign addr_l = in_beat2 ? hi_idx_q : req_idx;
    assign we_l   = wr_lo ? be8[l] : (wr_hi && hi_be_q[l]);
    assign wd_l   = in_beat2 ? hi_data_q[8*l +: 8] : data64[8*l +: 8];

    always_ff @(posedge clk) begin
      if (we_l) mem[addr_l] <= wd_l;
      if (accept) rd_lo_b <= mem[addr_l];
    end
    assign rd_lo[8*l +: 8] = rd_lo_b;

    // Lane 3 of word W+1 can never land in a 32-bit result.
    if (l < 3) begin : g_hi
      logic [7:0] rd_hi_b;
      always_ff @(posedge clk) begin
        if (in_beat2) rd_hi_b <= mem[addr_l];
      end
      assign rd_hi[8*l +: 8] = rd_hi_b;
    end
  end

  logic [31:0] raw, ext;

  always_comb begin
    raw = rd_lo;
    case (off_q)
      2'd1:    raw = {rd_hi[7:0],  rd_lo[31:8]};
      2'd2:    raw = {rd_hi[15:0], rd_lo[31:16]};
      2'd3:    raw = {rd_hi[23:0], rd_lo[31:24]};
      default: raw = rd_lo;
    endcase
  end

  dmem_ext u_ext (
    .sel (type_q),
    .raw (raw),
    .ext (ext)
  );

  assign req_ready = (state == IDLE) && started;
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !st_q) ? ext : 32'd0;
  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: default instance plus one with misaligned splits disabled.
module tb_dmem_lsu;
  import dmem_pkg::*;

  logic clk;
  logic rst_n;
  state_t st_a, st_b;

  dmem_lsu_if bus_a ();
  dmem_lsu_if bus_b ();

  int pass_cnt = 0;
  int total_cnt = 0;

  dmem_lsu #(.DEPTH_WORDS(256), .ALLOW_MISALIGNED(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(bus_a.req_valid), .req_ready(bus_a.req_ready),
    .req_addr(bus_a.req_addr), .req_wdata(bus_a.req_wdata),
    .req_sltype(bus_a.req_sltype), .rsp_valid(bus_a.rsp_valid),
    .rsp_rdata(bus_a.rsp_rdata), .rsp_err(bus_a.rsp_err),
    .dbg_state(st_a)
  );

  dmem_lsu #(.DEPTH_WORDS(256), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(bus_b.req_valid), .req_ready(bus_b.req_ready),
    .req_addr(bus_b.req_addr), .req_wdata(bus_b.req_wdata),
    .req_sltype(bus_b.req_sltype), .rsp_valid(bus_b.rsp_valid),
    .rsp_rdata(bus_b.rsp_rdata), .rsp_err(bus_b.rsp_err),
    .dbg_state(st_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [3:0]  sltype;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic add(input int sel, input logic [3:0] t, input logic [31:0] a,
                     input logic [31:0] w, input logic [31:0] rd, input logic er,
                     input int lat);
    vec_t v;
    v.sel = sel; v.sltype = t; v.addr = a; v.wdata = w;
    v.exp_rdata = rd; v.exp_err = er; v.exp_lat = lat;
    vecs.push_back(v);
  endtask

  function automatic logic ready_of(input int sel);
    return (sel == 0) ? bus_a.req_ready : bus_b.req_ready;
  endfunction

  function automatic logic rsp_of(input int sel);
    return (sel == 0) ? bus_a.rsp_valid : bus_b.rsp_valid;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [3:0] t,
                       input logic [31:0] a, input logic [31:0] w);
    if (sel == 0) begin
      bus_a.req_valid = v; bus_a.req_sltype = t; bus_a.req_addr = a; bus_a.req_wdata = w;
    end else begin
      bus_b.req_valid = v; bus_b.req_sltype = t; bus_b.req_addr = a; bus_b.req_wdata = w;
    end
  endtask

  // Issues one request; lat counts clocks from the accept edge to the response (-1 = none).
  task automatic run_req(input int sel, input logic [3:0] t, input logic [31:0] a,
                         input logic [31:0] w, output logic [31:0] rd, output logic er,
                         output int lat, output bit saw_b2, output bit pulse_ok);
    int guard;
    rd = 32'd0; er = 1'b0; lat = -1; saw_b2 = 1'b0; pulse_ok = 1'b0;
    @(negedge clk);
    drive(sel, 1'b1, t, a, w);
    guard = 0;
    while (!ready_of(sel) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 4'd0, 32'd0, 32'd0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (((sel == 0) ? st_a : st_b) == BEAT2) saw_b2 = 1'b1;
      if (rsp_of(sel)) begin
        lat = c;
        rd  = (sel == 0) ? bus_a.rsp_rdata : bus_b.rsp_rdata;
        er  = (sel == 0) ? bus_a.rsp_err : bus_b.rsp_err;
        break;
      end
    end
    @(negedge clk);
    pulse_ok = (lat > 0) && !rsp_of(sel);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  bit          saw_b2, pulse_ok, saw_rsp;

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0);

    // Reset state while held.
    repeat (3) @(negedge clk);
    check32("rst_ready", {31'd0, bus_a.req_ready}, 32'd0);
    check32("rst_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    check32("rst_rdata", bus_a.rsp_rdata, 32'd0);
    check32("rst_err", {31'd0, bus_a.rsp_err}, 32'd0);
    check32("rst_state", {30'd0, st_a}, {30'd0, IDLE});
    rst_n = 1'b1;
    @(negedge clk);
    check32("ready_after_rst", {31'd0, bus_a.req_ready}, 32'd1);

    // Zero the words the expectations depend on.
    add(0, SLT_SW,  32'h20, 32'h0, 32'h0, 1'b0, 1);
    add(0, SLT_SW,  32'h24, 32'h0, 32'h0, 1'b0, 1);
    add(0, SLT_SW,  32'h30, 32'h0, 32'h0, 1'b0, 1);
    add(0, SLT_SW,  32'h34, 32'h0, 32'h0, 1'b0, 1);
    add(0, SLT_SW,  32'h3FC, 32'h0, 32'h0, 1'b0, 1);
    add(0, SLT_SW,  32'h00, 32'h0, 32'h0, 1'b0, 1);
    // Aligned word and byte-lane behaviour.
    add(0, SLT_SW,  32'h10, 32'h11223344, 32'h0, 1'b0, 1);
    add(0, SLT_LW,  32'h10, 32'h0, 32'h11223344, 1'b0, 1);
    add(0, SLT_SB,  32'h13, 32'h55AA00AB, 32'h0, 1'b0, 1);
    add(0, SLT_LB,  32'h13, 32'h0, 32'hFFFFFFAB, 1'b0, 1);
    add(0, SLT_LBU, 32'h13, 32'h0, 32'h000000AB, 1'b0, 1);
    add(0, SLT_LW,  32'h10, 32'h0, 32'hAB223344, 1'b0, 1);
    add(0, SLT_SH,  32'h12, 32'h12348001, 32'h0, 1'b0, 1);
    add(0, SLT_LW,  32'h10, 32'h0, 32'h80013344, 1'b0, 1);
    add(0, SLT_LH,  32'h12, 32'h0, 32'hFFFF8001, 1'b0, 1);
    add(0, SLT_LHU, 32'h12, 32'h0, 32'h00008001, 1'b0, 1);
    add(0, SLT_LB,  32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 1);
    add(0, SLT_LBU, 32'h12, 32'h0, 32'h00000001, 1'b0, 1);
    add(0, SLT_LH,  32'h10, 32'h0, 32'h00003344, 1'b0, 1);
    // Split accesses.
    add(0, SLT_SW,  32'h22, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    add(0, SLT_LW,  32'h20, 32'h0, 32'hBEEF0000, 1'b0, 1);
    add(0, SLT_LHU, 32'h24, 32'h0, 32'h0000DEAD, 1'b0, 1);
    add(0, SLT_LW,  32'h22, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    add(0, SLT_LH,  32'h23, 32'h0, 32'hFFFFADBE, 1'b0, 2);
    // Range and encoding errors.
    add(0, SLT_SW,  32'h3FE, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    add(0, SLT_LW,  32'h3FC, 32'h0, 32'h0, 1'b0, 1);
    add(0, SLT_LW,  32'h00, 32'h0, 32'h0, 1'b0, 1);
    add(0, SLT_LW,  32'h400, 32'h0, 32'h0, 1'b1, 1);
    add(0, SLT_LH,  32'h3FF, 32'h0, 32'h0, 1'b1, 1);
    add(0, SLT_LB,  32'h3FF, 32'h0, 32'h0, 1'b0, 1);
    add(0, 4'b0011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    // Misaligned accesses disabled.
    add(1, SLT_SW,  32'h04, 32'h01020304, 32'h0, 1'b0, 1);
    add(1, SLT_LH,  32'h03, 32'h0, 32'h0, 1'b1, 1);
    add(1, SLT_LW,  32'h04, 32'h0, 32'h01020304, 1'b0, 1);
    add(1, SLT_SH,  32'h07, 32'h0000FFFF, 32'h0, 1'b1, 1);
    add(1, SLT_LW,  32'h04, 32'h0, 32'h01020304, 1'b0, 1);
    add(1, SLT_LW,  32'h05, 32'h0, 32'h0, 1'b1, 1);
    add(1, 4'b0011, 32'h04, 32'h0, 32'h0, 1'b1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_req(vecs[i].sel, vecs[i].sltype, vecs[i].addr, vecs[i].wdata,
              rd, er, lat, saw_b2, pulse_ok);
      check32($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check32($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      check32($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check32($sformatf("v%0d_beat2_seen", i), {31'd0, saw_b2},
              {31'd0, (vecs[i].exp_lat == 2)});
      check32($sformatf("v%0d_rsp_pulse", i), {31'd0, pulse_ok}, 32'd1);
    end

    // Reset during BEAT2 of a split store.
    @(negedge clk);
    drive(0, 1'b1, SLT_SW, 32'h32, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    check32("midrst_in_beat2", {30'd0, st_a}, {30'd0, BEAT2});
    #1;
    rst_n = 1'b0;
    saw_rsp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus_a.rsp_valid) saw_rsp = 1'b1;
    end
    check32("midrst_no_rsp", {31'd0, saw_rsp}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check32("midrst_ready", {31'd0, bus_a.req_ready}, 32'd1);
    run_req(0, SLT_LW, 32'h30, 32'h0, rd, er, lat, saw_b2, pulse_ok);
    check32("midrst_word_w", rd, 32'hF00D0000);
    run_req(0, SLT_LW, 32'h34, 32'h0, rd, er, lat, saw_b2, pulse_ok);
    check32("midrst_word_w1", rd, 32'h00000000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
